pc_unit: RTL

Parametrised program-counter unit for the MIPS fetch stage, successor to the plain `pc` register. It holds the fetch PC and selects the next PC from sequential increment, branch, jump/call, return, exception and exception-return sources. It keeps a small return-address stack (RAS) and an exception PC (EPC). It sits between the fetch address mux and instruction memory and takes redirect requests from decode/execute.

---
 rtl/pc_unit_if.sv | 35 +++
 rtl/pc_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Fetch-stage redirect/PC bundle between the decode/execute request sources
// (master) and the program-counter unit (slave).
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  // Redirect requests, single-cycle levels sampled on every clock edge
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic [WIDTH-1:0] jump_target;
  logic             ret;
  logic             exception;
  logic             eret;

  // PC unit state visible to fetch
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] epc_out;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, branch_taken, branch_target, jump, call, jump_target,
           ret, exception, eret,
    input  pc_out, pc_plus_step, epc_out, ras_empty, ras_full
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, call, jump_target,
           ret, exception, eret,
    output pc_out, pc_plus_step, epc_out, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage: holds the fetch PC, selects
// the next PC from sequential/branch/jump/call/return/exception/eret sources,
// and keeps a circular return-address stack plus the exception PC.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00000000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h80000180,
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  // One decoded action per cycle, already resolved by priority
  typedef enum logic [3:0] {
    OP_SEQ,
    OP_EXC,
    OP_ERET,
    OP_HOLD,
    OP_POP,
    OP_SWAP,
    OP_PUSH,
    OP_JUMP,
    OP_BRANCH
  } op_e;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;

  op_e              w_op;
  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_ras_top;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_epc_nxt;
  logic [PW-1:0]    w_top_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_ras_we;
  logic [PW-1:0]    w_ras_widx;
  logic [WIDTH-1:0] w_ras_wdata;

  assign w_pc_plus = r_pc + WIDTH'(STEP);
  assign w_ras_top = r_ras[r_top];

  // Resolve the request priority into a single action.
  // An empty-stack ret is checked after call so that call+ret on an empty
  // stack behaves as a plain call, and before jump so it still beats jump.
  always_comb begin
    w_op = OP_SEQ;
    if (bus.exception) begin
      w_op = OP_EXC;
    end else if (bus.eret) begin
      w_op = OP_ERET;
    end else if (bus.stall) begin
      w_op = OP_HOLD;
    end else if (bus.ret && !r_empty) begin
      w_op = bus.call ? OP_SWAP : OP_POP;
    end else if (bus.call) begin
      w_op = OP_PUSH;
    end else if (bus.ret) begin
      w_op = OP_SEQ;
    end else if (bus.jump) begin
      w_op = OP_JUMP;
    end else if (bus.branch_taken) begin
      w_op = OP_BRANCH;
    end
  end

  // Next PC, EPC and return-stack bookkeeping for the selected action
  always_comb begin
    w_pc_nxt    = w_pc_plus;
    w_epc_nxt   = r_epc;
    w_top_nxt   = r_top;
    w_count_nxt = r_count;
    w_ras_we    = 1'b0;
    w_ras_widx  = r_top;
    w_ras_wdata = w_pc_plus;
    unique case (w_op)
      OP_EXC: begin
        w_pc_nxt  = EXC_VECTOR;
        w_epc_nxt = r_pc;
      end
      OP_ERET: begin
        w_pc_nxt = r_epc;
      end
      OP_HOLD: begin
        w_pc_nxt = r_pc;
      end
      OP_POP: begin
        w_pc_nxt    = w_ras_top;
        w_top_nxt   = r_top - PW'(1);
        w_count_nxt = r_count - CW'(1);
      end
      OP_SWAP: begin
        w_pc_nxt   = w_ras_top;
        w_ras_we   = 1'b1;
        w_ras_widx = r_top;
      end
      OP_PUSH: begin
        // When full, the slot after top is the oldest entry and gets reused
        w_pc_nxt    = bus.jump_target;
        w_ras_we    = 1'b1;
        w_ras_widx  = r_top + PW'(1);
        w_top_nxt   = r_top + PW'(1);
        w_count_nxt = r_full ? r_count : r_count + CW'(1);
      end
      OP_JUMP: begin
        w_pc_nxt = bus.jump_target;
      end
      OP_BRANCH: begin
        w_pc_nxt = bus.branch_target;
      end
      default: begin
        w_pc_nxt = w_pc_plus;
      end
    endcase
  end

  // PC, EPC, stack pointer/count and the registered stack flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_top   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
      r_top   <= w_top_nxt;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(RAS_DEPTH));
    end
  end

  // Stack storage has no reset; contents are only read when count > 0
  always_ff @(posedge clk) begin
    if (reset && w_ras_we) begin
      r_ras[w_ras_widx] <= w_ras_wdata;
    end
  end

  assign bus.pc_out       = r_pc;
  assign bus.pc_plus_step = w_pc_plus;
  assign bus.epc_out      = r_epc;
  assign bus.ras_empty    = r_empty;
  assign bus.ras_full     = r_full;

endmodule
